// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - Shared constants, saturating add, symbol codes and FSM types for the SW PE
package sw_pkg;

  localparam longint NEG_INF = 0;

  localparam logic [1:0] NT_A = 2'd0;
  localparam logic [1:0] NT_C = 2'd1;
  localparam logic [1:0] NT_G = 2'd2;
  localparam logic [1:0] NT_T = 2'd3;

  typedef enum logic {SC_IDLE, SC_CALC} score_state_t;
  typedef enum logic {HI_IDLE, HI_CALC} high_state_t;

  // Biased score zero point for a given score width.
  function automatic longint zero_score(input int w);
    return longint'(1) << (w - 1);
  endfunction

  // Unsigned biased score plus signed penalty, clamped to [0, 2^w-1].
  function automatic longint sat_add(input longint a, input longint b, input int w);
    longint s;
    longint hi;
    s  = a + b;
    hi = (longint'(1) << w) - 1;
    if (s < 0) return 0;
    if (s > hi) return hi;
    return s;
  endfunction

endpackage

// File: rtl/sw_sat_add.sv
// rtl/sw_sat_add.sv - Biased score plus signed penalty with saturation
module sw_sat_add
  import sw_pkg::*;
#(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = W'(sat_add(longint'(a), longint'($signed(b)), W));

endmodule

// File: rtl/sw_pe_affine.sv
// rtl/sw_pe_affine.sv - Affine-gap Smith-Waterman systolic PE; SW_PE_POS_TRACK_EN adds best-cell tracking
module sw_pe_affine
  import sw_pkg::*;
#(
  parameter int SCORE_WIDTH = 12,
  parameter int SYM_WIDTH   = 2,
  parameter int POS_WIDTH   = 16,
  parameter int PE_INDEX    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_in,
  input  logic                   last_in,
  input  logic [SYM_WIDTH-1:0]   sym_in,
  input  logic [SYM_WIDTH-1:0]   query,
  input  logic [SCORE_WIDTH-1:0] M_in,
  input  logic [SCORE_WIDTH-1:0] I_in,
  input  logic [SCORE_WIDTH-1:0] D_in,
  input  logic [SCORE_WIDTH-1:0] High_in,
  input  logic [SCORE_WIDTH-1:0] match,
  input  logic [SCORE_WIDTH-1:0] mismatch,
  input  logic [SCORE_WIDTH-1:0] gap_open,
  input  logic [SCORE_WIDTH-1:0] gap_extend,
`ifdef SW_PE_POS_TRACK_EN
  input  logic [POS_WIDTH-1:0]   best_col_in,
  input  logic [POS_WIDTH-1:0]   best_row_in,
  output logic [POS_WIDTH-1:0]   best_col,
  output logic [POS_WIDTH-1:0]   best_row,
`endif
  output logic                   en_out,
  output logic                   last_out,
  output logic [SYM_WIDTH-1:0]   sym_out,
  output logic [SCORE_WIDTH-1:0] M_out,
  output logic [SCORE_WIDTH-1:0] I_out,
  output logic [SCORE_WIDTH-1:0] D_out,
  output logic [SCORE_WIDTH-1:0] High_out,
  output logic                   vld,
  output logic [SCORE_WIDTH-1:0] score_res
);

  localparam logic [SCORE_WIDTH-1:0] SC_ZERO = SCORE_WIDTH'(zero_score(SCORE_WIDTH));
  localparam logic [SCORE_WIDTH-1:0] SC_NEG  = SCORE_WIDTH'(NEG_INF);

  score_state_t s_state, s_next;
  high_state_t  h_state, h_next;
  logic         s_first, h_first;

  logic [SCORE_WIDTH-1:0] m_diag, i_diag, d_diag;
  logic [SCORE_WIDTH-1:0] sub, md, id, dd, mown, down, dmax_a, dmax;
  logic [SCORE_WIDTH-1:0] m_raw, m_new, io, i_pre, i_new, dop, d_pre, d_new;
  logic [SCORE_WIDTH-1:0] own_a, own, cand;
  logic                   nb_wins, take;

  // Score FSM
  always_ff @(posedge clk) begin
    if (!rst) s_state <= SC_IDLE;
    else      s_state <= s_next;
  end

  always_comb begin
    s_next = s_state;
    case (s_state)
      SC_IDLE: if (en_in && !last_in) s_next = SC_CALC;
      SC_CALC: if (en_in && last_in)  s_next = SC_IDLE;
      default: s_next = SC_IDLE;
    endcase
  end

  always_comb begin
    s_first = (s_state == SC_IDLE);
  end

  // A fresh sequence sees a zero diagonal and no open gap to its left.
  assign sub    = (sym_in == query) ? match : mismatch;
  assign md     = s_first ? SC_ZERO : m_diag;
  assign id     = s_first ? SC_NEG  : i_diag;
  assign dd     = s_first ? SC_NEG  : d_diag;
  assign mown   = s_first ? SC_ZERO : M_out;
  assign down   = s_first ? SC_NEG  : D_out;
  assign dmax_a = (md > id) ? md : id;
  assign dmax   = (dmax_a > dd) ? dmax_a : dd;
  assign m_new  = (m_raw > SC_ZERO) ? m_raw : SC_ZERO;
  assign i_pre  = (io > I_in) ? io : I_in;
  assign d_pre  = (dop > down) ? dop : down;

  sw_sat_add #(.W(SCORE_WIDTH)) u_add_m  (.a(dmax),  .b(sub),        .y(m_raw));
  sw_sat_add #(.W(SCORE_WIDTH)) u_add_io (.a(M_in),  .b(gap_open),   .y(io));
  sw_sat_add #(.W(SCORE_WIDTH)) u_add_ie (.a(i_pre), .b(gap_extend), .y(i_new));
  sw_sat_add #(.W(SCORE_WIDTH)) u_add_do (.a(mown),  .b(gap_open),   .y(dop));
  sw_sat_add #(.W(SCORE_WIDTH)) u_add_de (.a(d_pre), .b(gap_extend), .y(d_new));

  always_ff @(posedge clk) begin
    if (!rst) begin
      en_out   <= 1'b0;
      last_out <= 1'b0;
      sym_out  <= '0;
      M_out    <= SC_ZERO;
      I_out    <= SC_ZERO;
      D_out    <= SC_ZERO;
      m_diag   <= SC_ZERO;
      i_diag   <= SC_NEG;
      d_diag   <= SC_NEG;
    end else begin
      en_out   <= en_in;
      last_out <= en_in & last_in;
      if (en_in) begin
        sym_out <= sym_in;
        M_out   <= m_new;
        I_out   <= i_new;
        D_out   <= d_new;
        m_diag  <= M_in;
        i_diag  <= I_in;
        d_diag  <= D_in;
      end
    end
  end

  // High FSM
  always_ff @(posedge clk) begin
    if (!rst) h_state <= HI_IDLE;
    else      h_state <= h_next;
  end

  always_comb begin
    h_next = h_state;
    case (h_state)
      HI_IDLE: if (en_out && !last_out) h_next = HI_CALC;
      HI_CALC: if (en_out && last_out)  h_next = HI_IDLE;
      default: h_next = HI_IDLE;
    endcase
  end

  always_comb begin
    h_first = (h_state == HI_IDLE);
  end

  // Neighbour maximum wins ties so the earliest row keeps ownership.
  assign own_a   = (M_out > I_out) ? M_out : I_out;
  assign own     = (own_a > D_out) ? own_a : D_out;
  assign nb_wins = (High_in >= own);
  assign cand    = nb_wins ? High_in : own;
  assign take    = h_first || (cand > High_out);

  always_ff @(posedge clk) begin
    if (!rst) begin
      High_out  <= SC_ZERO;
      score_res <= SC_ZERO;
      vld       <= 1'b0;
    end else begin
      vld <= en_out & last_out;
      if (en_out) begin
        if (take)     High_out  <= cand;
        if (last_out) score_res <= take ? cand : High_out;
      end
    end
  end

`ifdef SW_PE_POS_TRACK_EN
  logic [POS_WIDTH-1:0] col_cnt, col_now, cand_col, cand_row, run_col, run_row;

  assign col_now  = h_first ? '0 : col_cnt;
  assign cand_col = nb_wins ? best_col_in : col_now;
  assign cand_row = nb_wins ? best_row_in : POS_WIDTH'(PE_INDEX);

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_cnt  <= '0;
      run_col  <= '0;
      run_row  <= '0;
      best_col <= '0;
      best_row <= '0;
    end else if (en_out) begin
      col_cnt <= col_now + 1'b1;
      if (take) begin
        run_col <= cand_col;
        run_row <= cand_row;
      end
      if (last_out) begin
        best_col <= take ? cand_col : run_col;
        best_row <= take ? cand_row : run_row;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sw_pe_affine.sv
// tb/tb_sw_pe_affine.sv - Scoreboard bench for sw_pe_affine against a recurrence-level model
module tb_sw_pe_affine;
  import sw_pkg::*;

  localparam int ZERO = 2048;
  localparam int NEG  = 0;
  localparam int MAXS = 4095;
  localparam int II   = NEG;
  localparam int DI   = ZERO;
  localparam int HI   = ZERO;
  localparam int PEI  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        en_in = 1'b0, last_in = 1'b0;
  logic [1:0]  sym_in = '0, query = '0;
  logic [11:0] M_in = 12'(ZERO), I_in = 12'(II), D_in = 12'(DI), High_in = 12'(HI);
  logic [11:0] match = '0, mismatch = '0, gap_open = '0, gap_extend = '0;
  logic        en_out, last_out, vld;
  logic [1:0]  sym_out;
  logic [11:0] M_out, I_out, D_out, High_out, score_res;
`ifdef SW_PE_POS_TRACK_EN
  logic [15:0] best_col_in = '0, best_row_in = '0, best_col, best_row;
`endif

  sw_pe_affine #(.SCORE_WIDTH(12), .SYM_WIDTH(2), .POS_WIDTH(16), .PE_INDEX(PEI)) dut (
    .clk(clk), .rst(rst), .en_in(en_in), .last_in(last_in), .sym_in(sym_in), .query(query),
    .M_in(M_in), .I_in(I_in), .D_in(D_in), .High_in(High_in),
    .match(match), .mismatch(mismatch), .gap_open(gap_open), .gap_extend(gap_extend),
`ifdef SW_PE_POS_TRACK_EN
    .best_col_in(best_col_in), .best_row_in(best_row_in), .best_col(best_col), .best_row(best_row),
`endif
    .en_out(en_out), .last_out(last_out), .sym_out(sym_out),
    .M_out(M_out), .I_out(I_out), .D_out(D_out), .High_out(High_out),
    .vld(vld), .score_res(score_res)
  );

  typedef struct { int m; int i; int d; } cell_t;
  typedef struct { int score; int col; int row; } res_t;
  typedef struct { bit en; bit last; bit vld; bit rchk; } cyc_t;

  cell_t cell_q[$];
  res_t  res_q[$];
  cyc_t  cyc_q[$];

  int tests = 0, fails = 0;
  int seq_sym[16], seq_mi[16], seq_bub[16];
  int q = 0, pm = 0, pmm = 0, pgo = 0, pge = 0;
  bit prev_el = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int clip(input int v);
    return (v < 0) ? 0 : ((v > MAXS) ? MAXS : v);
  endfunction

  function automatic int mx(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Gotoh recurrence for one row against a constant left neighbour (varying M_in).
  task automatic model_seq(input int n, input bit complete);
    int m, i, d, mprev, dprev, best, bcol, brow, sub, diag, own, cand, ccol, crow;
    mprev = ZERO; dprev = NEG; best = 0; bcol = 0; brow = 0;
    for (int j = 0; j < n; j++) begin
      sub  = (seq_sym[j] == q) ? pm : pmm;
      diag = (j == 0) ? ZERO : mx(mx(seq_mi[j-1], II), DI);
      m = mx(ZERO, clip(diag + sub));
      i = clip(mx(clip(seq_mi[j] + pgo), II) + pge);
      d = clip(mx(clip(mprev + pgo), dprev) + pge);
      cell_q.push_back('{m, i, d});
      own = mx(m, mx(i, d));
      if (HI >= own) begin cand = HI; ccol = 0; crow = 0; end
      else begin cand = own; ccol = j; crow = PEI; end
      if (j == 0 || cand > best) begin best = cand; bcol = ccol; brow = crow; end
      mprev = m; dprev = d;
    end
    if (complete) res_q.push_back('{best, bcol, brow});
  endtask

  task automatic step(input bit r, input bit e, input bit l, input int s, input int mi);
    cyc_t c;
    rst = r; en_in = e; last_in = l; sym_in = 2'(s); M_in = 12'(mi);
    c.en = r & e; c.last = r & e & l; c.vld = r & prev_el; c.rchk = !r;
    prev_el = r & e & l;
    cyc_q.push_back(c);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int k);
    for (int n = 0; n < k; n++) step(1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 4095));
  endtask

  task automatic set_pen(input int a, input int b, input int c, input int d, input int qq);
    pm = a; pmm = b; pgo = c; pge = d; q = qq;
    match = 12'(a); mismatch = 12'(b); gap_open = 12'(c); gap_extend = 12'(d); query = 2'(qq);
  endtask

  task automatic run_seq(input int n, input int abort_at);
    model_seq((abort_at < 0) ? n : abort_at, abort_at < 0);
    for (int j = 0; j < n; j++) begin
      if (j > 0) idle(seq_bub[j]);
      if (abort_at == j) begin
        step(1'b0, 1'b1, 1'b0, seq_sym[j], seq_mi[j]);
        return;
      end
      step(1'b1, 1'b1, j == n - 1, seq_sym[j], seq_mi[j]);
    end
  endtask

  task automatic clear_seq();
    for (int j = 0; j < 16; j++) begin seq_mi[j] = ZERO; seq_bub[j] = 0; seq_sym[j] = 0; end
  endtask

  cyc_t  mc;
  cell_t ce;
  res_t  re;

  always @(negedge clk) begin
    if (cyc_q.size() > 0) begin
      mc = cyc_q.pop_front();
      chk("en_out", 32'(en_out), 32'(mc.en));
      chk("last_out", 32'(last_out), 32'(mc.last));
      chk("vld", 32'(vld), 32'(mc.vld));
      if (mc.rchk) begin
        chk("rst_M_out", 32'(M_out), ZERO);
        chk("rst_I_out", 32'(I_out), ZERO);
        chk("rst_D_out", 32'(D_out), ZERO);
        chk("rst_High_out", 32'(High_out), ZERO);
        chk("rst_score_res", 32'(score_res), ZERO);
        chk("rst_sym_out", 32'(sym_out), 0);
`ifdef SW_PE_POS_TRACK_EN
        chk("rst_best_col", 32'(best_col), 0);
        chk("rst_best_row", 32'(best_row), 0);
`endif
      end
      if (en_out) begin
        if (cell_q.size() == 0) chk("cell_unexpected", 1, 0);
        else begin
          ce = cell_q.pop_front();
          chk("M_out", 32'(M_out), ce.m);
          chk("I_out", 32'(I_out), ce.i);
          chk("D_out", 32'(D_out), ce.d);
        end
      end
      if (vld) begin
        if (res_q.size() == 0) chk("vld_unexpected", 1, 0);
        else begin
          re = res_q.pop_front();
          chk("score_res", 32'(score_res), re.score);
`ifdef SW_PE_POS_TRACK_EN
          chk("best_col", 32'(best_col), re.col);
          chk("best_row", 32'(best_row), re.row);
`endif
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, ab;
    #1;
    set_pen(2, -1, -3, -1, int'(NT_A));
    step(1'b0, 1'b0, 1'b0, 0, ZERO);
    step(1'b0, 1'b0, 1'b0, 0, ZERO);
    idle(1);

    clear_seq(); seq_sym[0] = int'(NT_A); run_seq(1, -1); idle(2);
    clear_seq(); seq_sym[0] = int'(NT_G); seq_sym[1] = int'(NT_A); run_seq(2, -1); idle(2);
    clear_seq(); seq_sym[0] = int'(NT_G); seq_sym[1] = int'(NT_A); seq_bub[1] = 1; run_seq(2, -1); idle(2);
    clear_seq(); seq_sym[0] = int'(NT_A); run_seq(1, -1);
    clear_seq(); seq_sym[0] = int'(NT_G); run_seq(1, -1); idle(2);

    set_pen(10, -1, -3, -1, int'(NT_A));
    clear_seq(); seq_sym[0] = int'(NT_G); seq_mi[0] = 4090; seq_sym[1] = int'(NT_A); run_seq(2, -1); idle(2);

    set_pen(2, -1, -3, -1, int'(NT_A));
    clear_seq();
    seq_sym[0] = int'(NT_A); seq_sym[1] = int'(NT_G); seq_sym[2] = int'(NT_A); seq_sym[3] = int'(NT_A);
    run_seq(4, 1); idle(2);
    clear_seq(); seq_sym[0] = int'(NT_G); seq_sym[1] = int'(NT_A); run_seq(2, -1); idle(2);

    for (int t = 0; t < 40; t++) begin
      set_pen($urandom_range(1, 10), -int'($urandom_range(0, 4)), -int'($urandom_range(1, 5)),
              -int'($urandom_range(0, 2)), $urandom_range(0, 3));
      clear_seq();
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) begin
        seq_sym[j] = $urandom_range(0, 3);
        seq_mi[j]  = ($urandom_range(0, 5) == 0) ? $urandom_range(4000, 4095) : 2040 + $urandom_range(0, 16);
        seq_bub[j] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      end
      ab = (n > 1 && $urandom_range(0, 9) == 0) ? $urandom_range(1, n - 1) : -1;
      run_seq(n, ab);
      idle($urandom_range(0, 2));
    end

    idle(4);
    @(negedge clk); #1;
    chk("cyc_q_drained", cyc_q.size(), 0);
    chk("cell_q_drained", cell_q.size(), 0);
    chk("res_q_drained", res_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sw_pe_affine.md
# sw_pe_affine

Next-generation Smith-Waterman systolic processing element.
- Parametrised in symbol width (DNA or protein alphabets) and score width.
- Keeps separate Gotoh affine-gap matrices I (vertical) and D (horizontal).
- Supports bubbles (stalls) inside a target stream and back-to-back target sequences delimited by a `last` flag.
- Reports a per-sequence best score with a one-cycle `vld` pulse.
- Instances chain left-to-right; PE k holds query symbol k and the target streams through.

## Interface
- `SCORE_WIDTH`, 12: score width; scores are unsigned biased by ZERO = 2^(SCORE_WIDTH-1).
- `SYM_WIDTH`, 2: symbol width; 2 for DNA, 5 for protein.
- `POS_WIDTH`, 16: column counter width.
- `PE_INDEX`, 0: row index reported with the best score.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low (already decided); clock `clk`.
- `en_in` in 1: target symbol valid; low = bubble.
- `last_in` in 1: the current symbol is the final one of its target sequence.
- `sym_in` in SYM_WIDTH: target symbol.
- `query` in SYM_WIDTH: this PE's query symbol.
- `M_in`, `I_in`, `D_in` in SCORE_WIDTH each: left neighbour's cell (k-1, j).
- `High_in` in SCORE_WIDTH: left neighbour's running maximum.
- `match`, `mismatch`, `gap_open`, `gap_extend` in SCORE_WIDTH each: two's-complement signed penalties.
- `en_out`, `last_out` out 1 each; `sym_out` out SYM_WIDTH: delayed copies of the inputs for the right neighbour.
- `M_out`, `I_out`, `D_out` out SCORE_WIDTH each: this PE's cell (k, j).
- `High_out` out SCORE_WIDTH: running maximum for the current sequence.
- `vld` out 1: one-cycle result pulse.
- `score_res` out SCORE_WIDTH: final best score.
- `best_col` out POS_WIDTH; `best_row` out POS_WIDTH: present only with SW_PE_POS_TRACK_EN.

## Operation
- NEG_INF is encoded as 0.
- Every addition is biased-score + signed penalty and saturates to the range [0, 2^SCORE_WIDTH-1].
- Score stage, on an enabled cycle:
  - sub = (sym_in == query) ? match : mismatch.
  - M = max(ZERO, sub + max(M_diag, I_diag, D_diag)).
  - I = max(M_in + gap_open, I_in) + gap_extend.
  - D = max(M_out + gap_open, D_out) + gap_extend.
  - M_diag/I_diag/D_diag then load M_in/I_in/D_in.
- First column of a sequence: own M_out, diag M = ZERO and own D_out, I_diag, D_diag = NEG_INF.
- Score FSM:
  - IDLE→CALC on en_in.
  - CALC→IDLE on en_in && last_in.
  - CALC stays in CALC on a bubble; all score registers hold.
  - A bubble drives en_out=0 and last_out=0.
- After last_in, the next enabled symbol starts a fresh sequence with no gap cycle required.
- High stage, on cycles where en_out=1:
  - cand = max(M_out, I_out, D_out, High_in).
  - On the first cell of a sequence, High_out = cand; afterwards High_out = max(High_out, cand).
  - On the cell where last_out=1, that value also loads score_res, and vld pulses the following cycle.
- High FSM:
  - IDLE→CALC on en_out.
  - CALC→IDLE on en_out && last_out.
  - CALC stays in CALC on a bubble (hold).
- Reset values: all score outputs, High_out and score_res = ZERO; en_out, last_out, vld = 0; sym_out = 0; best_col = 0; best_row = 0.
- `rst` low at any time discards the in-flight sequence; no vld is produced for it.

## Timing
- Score outputs and the en/last/sym copies are registered: input at edge t appears at t+1.
- High_out updates at t+2.
- vld is high for exactly one cycle, at t+2 relative to the last_in symbol; score_res is stable from then until the next vld.
- Back-to-back sequences: consecutive vld pulses can be one cycle apart.
- Per-PE chain latency: 1 cycle.

## Configuration
- `SW_PE_POS_TRACK_EN` defined:
  - A column counter (reset per sequence, advances only on enabled cycles) runs in the high stage.
  - best_col/best_row track the cell with the strictly greater score; ties keep the incumbent, and a neighbour-supplied maximum wins ties over the own cell.
  - Values are latched alongside score_res.
  - Adds ports `best_col_in`/`best_row_in`/`best_col`/`best_row` for chaining.
- Undefined: no counter, no position ports, no position logic.

## Structure
- Package `sw_pkg`: ZERO/NEG_INF constants, the saturating add function, nucleotide symbol encodings, FSM state typedefs.
- Sub-module `sw_sat_add` (biased + signed, saturating add), instantiated for every penalty addition.

## Test plan
Common setup: SCORE_WIDTH=12, match=+2, mismatch=-1, gap_open=-3, gap_extend=-1, neighbour inputs tied to ZERO / NEG_INF / ZERO.
- Query A, target "A" with last -> vld at t+2, score_res=2050, best_col=0.
- Target "GA" -> col0 M clamps to 2048, col1 M=2050; score_res=2050, best_col=1.
- Target "G", bubble, "A" (last on A) -> identical result to the "GA" case; en_out low for exactly one cycle.
- Back-to-back "A"(last) then "G"(last) -> two vld pulses one cycle apart; score_res 2050 then 2048.
- match=+10 with M_in=4090 on the first cycle, then a matching symbol -> M_out saturates to 4095, with no wrap.
- rst low on cycle 2 of a 4-symbol target -> all outputs return to reset values and no vld is produced; a following sequence scores correctly.
